// File: rtl/regs_wb_arb_if.sv
// Write-back arbiter bus: EX and long-latency result ports, the register-file
// write port, the ID hazard query and the buffer occupancy.
interface regs_wb_arb_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          ex_wen_i;
  logic [4:0]    ex_waddr_i;
  logic [31:0]   ex_wdata_i;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [4:0]    lsu_waddr_i;
  logic [31:0]   lsu_wdata_i;
  logic          reg_wen_o;
  logic [4:0]    reg_waddr_o;
  logic [31:0]   reg_wdata_o;
  logic [4:0]    id_raddr1_i;
  logic [4:0]    id_raddr2_i;
  logic          id_stall_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  ex_wen_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  id_raddr1_i, id_raddr2_i,
    output lsu_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o,
    output id_stall_o, count_o
  );

  modport master (
    output ex_wen_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output id_raddr1_i, id_raddr2_i,
    input  lsu_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o,
    input  id_stall_o, count_o
  );
endinterface

// File: rtl/regs_wb_arb.sv
// Register-file write-back arbiter: EX results win the single write port,
// long-latency results queue in a small FIFO with WAW kill and ID hazard stall.
module regs_wb_arb #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  regs_wb_arb_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_occ  [DEPTH];
  logic          r_vld  [DEPTH];
  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic          r_wen;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;

  logic          w_ex_sel;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_ready;
  logic          w_push_acc;
  logic          w_push;
  logic          w_head_vld;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic          w_hit1;
  logic          w_hit2;
  logic          w_stall;

  assign w_ex_sel    = bus.ex_wen_i && (bus.ex_waddr_i != 5'd0);
  assign w_empty     = (r_count == CW'(0));
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = !rst && !w_ex_sel && !w_empty;
  assign w_ready     = !rst && (!w_full || w_pop);
  assign w_push_acc  = bus.lsu_valid_i && w_ready;
  // A zero destination is acknowledged to the LSU but never stored.
  assign w_push      = w_push_acc && (bus.lsu_waddr_i != 5'd0);
  assign w_head_vld  = r_vld[r_rptr];
  assign w_head_addr = r_addr[r_rptr];
  assign w_head_data = r_data[r_rptr];

  // Hazard search over valid live entries, the popping head and the incoming push.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_occ[i] && r_vld[i]) begin
        if (r_addr[i] == bus.id_raddr1_i) w_hit1 = 1'b1;
        if (r_addr[i] == bus.id_raddr2_i) w_hit2 = 1'b1;
      end
    end
    if (w_pop && w_head_vld) begin
      if (w_head_addr == bus.id_raddr1_i) w_hit1 = 1'b1;
      if (w_head_addr == bus.id_raddr2_i) w_hit2 = 1'b1;
    end
    if (w_push) begin
      if (bus.lsu_waddr_i == bus.id_raddr1_i) w_hit1 = 1'b1;
      if (bus.lsu_waddr_i == bus.id_raddr2_i) w_hit2 = 1'b1;
    end
  end

  assign w_stall = !rst &&
                   (((bus.id_raddr1_i != 5'd0) && w_hit1) ||
                    ((bus.id_raddr2_i != 5'd0) && w_hit2));

  // FIFO storage: kill first, then pop release, then the push may reuse a freed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_occ[i]  <= 1'b0;
        r_vld[i]  <= 1'b0;
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'h0;
      end
    end else begin
      if (w_ex_sel) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (r_occ[i] && (r_addr[i] == bus.ex_waddr_i)) r_vld[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_occ[r_rptr] <= 1'b0;
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PW'(1);
      end
      if (w_push) begin
        r_occ[r_wptr]  <= 1'b1;
        r_vld[r_wptr]  <= 1'b1;
        r_addr[r_wptr] <= bus.lsu_waddr_i;
        r_data[r_wptr] <= bus.lsu_wdata_i;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Register-file write port, one cycle after source selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'h0;
    end else if (w_ex_sel) begin
      r_wen   <= 1'b1;
      r_waddr <= bus.ex_waddr_i;
      r_wdata <= bus.ex_wdata_i;
    end else if (w_pop) begin
      r_wen   <= w_head_vld;
      r_waddr <= w_head_addr;
      r_wdata <= w_head_data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign bus.lsu_ready_o = w_ready;
  assign bus.id_stall_o  = w_stall;
  assign bus.reg_wen_o   = r_wen;
  assign bus.reg_waddr_o = r_waddr;
  assign bus.reg_wdata_o = r_wdata;
  assign bus.count_o     = r_count;

endmodule

// File: tb/tb_regs_wb_arb.sv
// Directed vector bench for regs_wb_arb (DEPTH=4): sequential table of
// stimulus/expected records plus a streaming sequence across pointer wrap.
module tb_regs_wb_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  regs_wb_arb_if #(.DEPTH(4)) bus ();

  regs_wb_arb #(.DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        exw;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_stall;
    logic        e_wen;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic rs, input logic ew, input logic [4:0] ea,
                            input logic [31:0] ed, input logic lv, input logic [4:0] la,
                            input logic [31:0] ld, input logic [4:0] r1, input logic [4:0] r2,
                            input logic rdy, input logic stl, input logic wen,
                            input logic [4:0] a, input logic [31:0] d, input logic [2:0] cnt);
    vec_t t;
    t.rst = rs; t.exw = ew; t.exa = ea; t.exd = ed; t.lv = lv; t.la = la; t.ld = ld;
    t.r1 = r1; t.r2 = r2; t.e_rdy = rdy; t.e_stall = stl; t.e_wen = wen;
    t.e_a = a; t.e_d = d; t.e_cnt = cnt;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst             = t.rst;
    bus.ex_wen_i    = t.exw;
    bus.ex_waddr_i  = t.exa;
    bus.ex_wdata_i  = t.exd;
    bus.lsu_valid_i = t.lv;
    bus.lsu_waddr_i = t.la;
    bus.lsu_wdata_i = t.ld;
    bus.id_raddr1_i = t.r1;
    bus.id_raddr2_i = t.r2;
  endtask

  // Drive at negedge, check combinational outputs, then registered outputs after the edge.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    chk("lsu_ready", idx, 32'(bus.lsu_ready_o), 32'(t.e_rdy));
    chk("id_stall",  idx, 32'(bus.id_stall_o),  32'(t.e_stall));
    @(posedge clk);
    #1;
    chk("reg_wen",   idx, 32'(bus.reg_wen_o),   32'(t.e_wen));
    chk("reg_waddr", idx, 32'(bus.reg_waddr_o), 32'(t.e_a));
    chk("reg_wdata", idx, bus.reg_wdata_o,      t.e_d);
    chk("count",     idx, 32'(bus.count_o),     32'(t.e_cnt));
    chk("no_x0_write", idx, 32'(bus.reg_wen_o && (bus.reg_waddr_o == 5'd0)), 32'd0);
  endtask

  initial begin
    vec_t t;
    //  rs ew ea  exd           lv la  ld     r1  r2  rdy stl wen a   d             cnt
    v(1, 0, 0,  32'h0,        0, 0,  32'h0, 0,  0,  0,  0,  0,  0,  32'h0,        0); // reset
    v(0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0, 0,  0,  1,  0,  1,  5,  32'hDEADBEEF, 0); // EX only
    v(0, 1, 10, 32'hA0,       1, 1,  32'h1, 1,  0,  1,  1,  1,  10, 32'hA0,       1); // EX + push x1
    v(0, 1, 11, 32'hA1,       1, 2,  32'h2, 0,  1,  1,  1,  1,  11, 32'hA1,       2);
    v(0, 1, 12, 32'hA2,       1, 3,  32'h3, 3,  0,  1,  1,  1,  12, 32'hA2,       3);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 2,  0,  1,  1,  1,  1,  32'h1,        2); // drain x1
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  0,  1,  0,  1,  2,  32'h2,        1);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  3,  1,  1,  1,  3,  32'h3,        0);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 3,  0,  1,  0,  0,  3,  32'h3,        0); // idle hold
    v(0, 1, 20, 32'h20,       1, 4,  32'h4, 0,  0,  1,  0,  1,  20, 32'h20,       1); // fill
    v(0, 1, 20, 32'h20,       1, 5,  32'h5, 0,  0,  1,  0,  1,  20, 32'h20,       2);
    v(0, 1, 20, 32'h20,       1, 6,  32'h6, 0,  0,  1,  0,  1,  20, 32'h20,       3);
    v(0, 1, 20, 32'h20,       1, 8,  32'h8, 0,  0,  1,  0,  1,  20, 32'h20,       4);
    v(0, 1, 20, 32'h20,       1, 9,  32'h9, 9,  0,  0,  0,  1,  20, 32'h20,       4); // full, refused
    v(0, 0, 0,  32'h0,        1, 9,  32'h9, 0,  9,  1,  1,  1,  4,  32'h4,        4); // push+pop at full
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  9,  1,  1,  1,  5,  32'h5,        3); // x9 hazard
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  9,  1,  1,  1,  6,  32'h6,        2);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  9,  1,  1,  1,  8,  32'h8,        1);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  9,  1,  1,  1,  9,  32'h9,        0); // x9 popped
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 0,  9,  1,  0,  0,  9,  32'h9,        0); // stall cleared
    v(0, 0, 0,  32'h0,        1, 7,  32'h11, 0, 0,  1,  0,  0,  9,  32'h9,        1); // buffer x7=11
    v(0, 1, 7,  32'h22,       0, 0,  32'h0, 7,  0,  1,  1,  1,  7,  32'h22,       1); // EX kills x7
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 7,  0,  1,  0,  0,  7,  32'h11,       0); // killed pop
    v(0, 1, 7,  32'h33,       1, 7,  32'h44, 7, 0,  1,  1,  1,  7,  32'h33,       1); // same-cycle x7
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 7,  0,  1,  1,  1,  7,  32'h44,       0);
    v(0, 0, 0,  32'h0,        1, 0,  32'h55, 0, 0,  1,  0,  0,  7,  32'h44,       0); // x0 push dropped
    v(0, 1, 0,  32'h66,       1, 12, 32'h12, 0, 0,  1,  0,  0,  7,  32'h44,       1); // EX x0 ignored
    v(0, 1, 0,  32'h77,       0, 0,  32'h0, 0,  0,  1,  0,  1,  12, 32'h12,       0); // EX x0 lets pop
    v(0, 1, 20, 32'h20,       1, 13, 32'h13, 0, 0,  1,  0,  1,  20, 32'h20,       1);
    v(0, 1, 20, 32'h20,       1, 14, 32'h14, 0, 0,  1,  0,  1,  20, 32'h20,       2);
    v(1, 0, 0,  32'h0,        1, 15, 32'h15, 13, 0, 0,  0,  0,  0,  32'h0,        0); // reset mid-drain
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 13, 14, 1, 0,  0,  0,  32'h0,        0);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 13, 14, 1, 0,  0,  0,  32'h0,        0);
    v(0, 0, 0,  32'h0,        0, 0,  32'h0, 13, 14, 1, 0,  0,  0,  32'h0,        0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Streaming: one push per cycle with EX idle; each push drains the previous entry.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      t = vecs[vecs.size() - 1];
      t.lv = (k <= 8);
      t.la = 5'(k);
      t.ld = 32'(k) * 32'h101;
      t.r1 = 5'd0;
      t.r2 = 5'd0;
      drive(t);
      #1;
      chk("stream_ready", 100 + k, 32'(bus.lsu_ready_o), 32'd1);
      @(posedge clk);
      #1;
      chk("stream_count", 100 + k, 32'(bus.count_o), (k <= 8) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("stream_wen",   100 + k, 32'(bus.reg_wen_o),   32'd1);
        chk("stream_waddr", 100 + k, 32'(bus.reg_waddr_o), 32'(k - 1));
        chk("stream_wdata", 100 + k, bus.reg_wdata_o,      32'(k - 1) * 32'h101);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regs_wb_arb.md
REGS_WB_ARB -- requirements
Module: regs_wb_arb

Interface
REQ-001 Parameter DEPTH, default 4, number of write-buffer entries; power of two, 2..16.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; the codebase names its ports clk and rst_n, and rst is the active-high counterpart here.
REQ-004 ex_wen_i  input  1  EX-stage single-cycle result write request; cannot be stalled.
REQ-005 ex_waddr_i  input  5  EX destination register index.
REQ-006 ex_wdata_i  input  32  EX result data.
REQ-007 lsu_valid_i  input  1  long-latency (load/mul/div) result offered.
REQ-008 lsu_ready_o  output  1  buffer accepts the offered result this cycle.
REQ-009 lsu_waddr_i  input  5  long-latency destination register index.
REQ-010 lsu_wdata_i  input  32  long-latency result data.
REQ-011 reg_wen_o  output  1  register-file write enable, registered.
REQ-012 reg_waddr_o  output  5  register-file write index, registered.
REQ-013 reg_wdata_o  output  32  register-file write data, registered.
REQ-014 id_raddr1_i, id_raddr2_i  input  5 each  ID-stage source register indices.
REQ-015 id_stall_o  output  1  ID must hold; a source register has a pending buffered write.
REQ-016 count_o  output  log2(DEPTH)+1  number of live buffer entries.

Function
REQ-017 Long-latency results are held in a DEPTH-entry FIFO; each entry stores a valid bit, a 5-bit index and 32-bit data.
REQ-018 Push: a push occurs when lsu_valid_i and lsu_ready_o are both high.
REQ-019 lsu_ready_o SHALL be 1 when count_o < DEPTH, or when count_o == DEPTH and a pop occurs this cycle (same-cycle push+pop at full allowed).
REQ-020 A push with lsu_waddr_i == 0 SHALL be accepted and discarded, with no entry allocated.
REQ-021 Each cycle the output port selects exactly one source; EX has fixed priority.
REQ-022 If ex_wen_i=1 and ex_waddr_i!=0: next-cycle outputs are reg_wen_o=1, reg_waddr_o=ex_waddr_i, reg_wdata_o=ex_wdata_i, and no pop occurs.
REQ-023 Otherwise, if the FIFO is non-empty, the head is popped; the next-cycle reg_wen_o equals the head valid bit, with the head index and data.
REQ-024 Otherwise, reg_wen_o=0 next cycle; reg_waddr_o and reg_wdata_o hold their previous values.
REQ-025 Latency is exactly one clock from selection to register-file write port.
REQ-026 WAW kill: when EX writes rd != 0, every live FIFO entry with a matching index has its valid bit cleared in that cycle; the entry stays occupied and pops later with reg_wen_o=0.
REQ-027 A push in the same cycle with lsu_waddr_i == ex_waddr_i SHALL be stored as valid; the LSU result is ordered after EX.
REQ-028 id_stall_o is combinational.
REQ-029 id_stall_o=1 iff a nonzero id_raddr1_i or id_raddr2_i matches:
  - any valid live FIFO entry,
  - the head being popped this cycle, or
  - an accepted nonzero push this cycle.
REQ-030 Pointers wrap modulo DEPTH.
REQ-031 count_o updates as follows:
  - +1 on push only,
  - -1 on pop only,
  - unchanged on push+pop or when idle.
REQ-032 Index 0 is never written: reg_wen_o SHALL never assert with reg_waddr_o=0.

Reset
REQ-033 rst=1 at a clock edge clears all of the following:
  - FIFO pointers, valid bits and count_o;
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=32'h0.
REQ-034 While rst=1: lsu_ready_o=0 and id_stall_o=0; a push offered during reset is dropped.
REQ-035 Reset mid-operation discards all buffered writes, and none reach the register file afterward.

Verification
REQ-036 EX write only: ex_wen_i=1, waddr=5, wdata=32'hDEADBEEF, FIFO empty -> next cycle reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=32'hDEADBEEF.
REQ-037 Priority/buffering: push 3 LSU entries (x1=1, x2=2, x3=3) while EX writes every cycle -> count_o=3 and no LSU write appears; EX idle 3 cycles -> writes x1, x2, x3 in order and count_o returns to 0.
REQ-038 Full boundary (DEPTH=4): fill 4 entries with EX busy -> lsu_ready_o=0; release EX for one cycle with lsu_valid_i=1 -> pop and push occur together and count_o stays 4.
REQ-039 WAW kill: buffered x7=32'h11 then EX writes x7=32'h22 -> reg_wdata_o=32'h22 with wen=1; the later x7 pop shows reg_wen_o=0, and x7 is never overwritten with 32'h11.
REQ-040 Hazard: buffered x9 with id_raddr2_i=9 -> id_stall_o=1; the stall clears in the cycle x9 is issued; id_raddr1_i=0 never stalls.
REQ-041 Reset mid-drain: 2 entries buffered, rst=1 for one cycle -> count_o=0, reg_wen_o=0, and no further writes occur.
